key_note_ctrl: RTL and testbench



---
 rtl/key_note_ctrl.sv | 147 ++++++++++++++
 tb/tb_key_note_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/key_note_ctrl.sv
// Debounced five-button MIDI note controller with auto-repeat, mute toggle and event strobe.
// Drives tonegen's code input and the LED display.
module key_note_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned REPEAT_DELAY    = 12500000,
    parameter int unsigned REPEAT_RATE     = 2500000,
    parameter int unsigned NOTE_RESET      = 69,
    parameter int unsigned CNT_W           = 24
) (
    input  logic       clk_25m,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_right,
    input  logic       btn_left,
    input  logic       btn_center,
    output logic [6:0] code,
    output logic       mute,
    output logic       key_event
);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
    typedef enum logic [2:0] {K_NONE, K_CENTER, K_UP, K_DOWN, K_RIGHT, K_LEFT} key_t;

    // Bit order doubles as the low-to-high index used by press/deb.
    logic [4:0] raw;
    logic [4:0] sync1, sync2, deb, deb_d, press;
    logic [CNT_W-1:0] dcnt [5];

    assign raw   = {btn_left, btn_right, btn_down, btn_up, btn_center};
    assign press = deb & ~deb_d;

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_d <= '0;
            for (int unsigned i = 0; i < 5; i++) dcnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            deb_d <= deb;
            for (int unsigned i = 0; i < 5; i++) begin
                if (sync2[i] == deb[i]) begin
                    dcnt[i] <= '0;
                end else if (dcnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb[i]  <= ~deb[i];
                    dcnt[i] <= '0;
                end else begin
                    dcnt[i] <= dcnt[i] + CNT_W'(1);
                end
            end
        end
    end

    function automatic key_t pick_dir(input logic [4:0] p);
        if (p[1])      return K_UP;
        else if (p[2]) return K_DOWN;
        else if (p[3]) return K_RIGHT;
        else if (p[4]) return K_LEFT;
        else           return K_NONE;
    endfunction

    function automatic logic key_held(input key_t k, input logic [4:0] d);
        case (k)
            K_UP:    return d[1];
            K_DOWN:  return d[2];
            K_RIGHT: return d[3];
            K_LEFT:  return d[4];
            default: return 1'b0;
        endcase
    endfunction

    state_t state, state_nxt;
    key_t   held, held_nxt, act, dir;
    logic [CNT_W-1:0] rcnt, rcnt_nxt;
    logic   expire;

    always_comb begin
        state_nxt = state;
        held_nxt  = held;
        rcnt_nxt  = rcnt;
        act       = K_NONE;
        dir       = pick_dir(press);
        expire    = (state == DELAY) ? (rcnt == CNT_W'(REPEAT_DELAY - 1))
                                     : (rcnt == CNT_W'(REPEAT_RATE - 1));
        case (state)
            IDLE: begin
                if (press[0]) begin
                    act = K_CENTER;
                end else if (dir != K_NONE) begin
                    act       = dir;
                    held_nxt  = dir;
                    rcnt_nxt  = '0;
                    state_nxt = DELAY;
                end
            end
            default: begin
                if (!key_held(held, deb)) begin
                    rcnt_nxt  = '0;
                    state_nxt = IDLE;
                end else if (press[0]) begin
                    // Holding rcnt at its terminal value defers an expiring repeat by one cycle.
                    act = K_CENTER;
                    if (!expire) rcnt_nxt = rcnt + CNT_W'(1);
                end else if (dir != K_NONE) begin
                    act       = dir;
                    held_nxt  = dir;
                    rcnt_nxt  = '0;
                    state_nxt = DELAY;
                end else if (expire) begin
                    act       = held;
                    rcnt_nxt  = '0;
                    state_nxt = REPEAT;
                end else begin
                    rcnt_nxt = rcnt + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            held      <= K_NONE;
            rcnt      <= '0;
            code      <= 7'(NOTE_RESET);
            mute      <= 1'b0;
            key_event <= 1'b0;
        end else begin
            state     <= state_nxt;
            held      <= held_nxt;
            rcnt      <= rcnt_nxt;
            key_event <= (act != K_NONE);
            case (act)
                K_CENTER: mute <= ~mute;
                K_UP:     code <= (code == 7'd127) ? 7'd127 : code + 7'd1;
                K_DOWN:   code <= (code == 7'd0)   ? 7'd0   : code - 7'd1;
                K_RIGHT:  code <= (code > 7'd115)  ? 7'd127 : code + 7'd12;
                K_LEFT:   code <= (code < 7'd12)   ? 7'd0   : code - 7'd12;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_key_note_ctrl.sv
// Scoreboard bench for key_note_ctrl: stimulus queues expected events, a monitor checks each key_event.
module tb_key_note_ctrl;

    logic       clk_25m = 1'b0;
    logic       rst_n   = 1'b0;
    logic [4:0] b       = '0;   // 0 center, 1 up, 2 down, 3 right, 4 left
    logic [6:0] code;
    logic       mute, key_event;

    key_note_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(20),
        .REPEAT_RATE(5),
        .NOTE_RESET(69),
        .CNT_W(8)
    ) dut (
        .clk_25m(clk_25m),
        .rst_n(rst_n),
        .btn_up(b[1]),
        .btn_down(b[2]),
        .btn_right(b[3]),
        .btn_left(b[4]),
        .btn_center(b[0]),
        .code(code),
        .mute(mute),
        .key_event(key_event)
    );

    always #20 clk_25m = ~clk_25m;

    int cyc = 0;
    always @(posedge clk_25m) cyc <= cyc + 1;

    typedef struct {
        logic [6:0] code;
        logic       mute;
        int         at;
    } ev_t;
    ev_t q[$];

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int c, input logic m, input int at);
        ev_t e;
        e.code = 7'(c);
        e.mute = m;
        e.at   = at;
        q.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_25m);
        #1;
    endtask

    always @(negedge clk_25m) begin : monitor
        ev_t e;
        if (rst_n === 1'b1) begin
            if (key_event === 1'b1) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_event: got code=%0d mute=%0d at cycle %0d, expected none", code, mute, cyc);
                end else begin
                    e = q.pop_front();
                    check("ev_cycle", cyc, e.at);
                    check("ev_code", code, e.code);
                    check("ev_mute", mute, e.mute);
                end
            end else if (q.size() > 0 && q[0].at < cyc) begin
                total++;
                bad++;
                $display("FAIL missing_event: none by cycle %0d, expected code=%0d at cycle %0d", cyc, q[0].code, q[0].at);
                void'(q.pop_front());
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        b     = '0;
        step(3);
        check("rst_code", code, 69);
        check("rst_mute", mute, 0);
        check("rst_event", key_event, 0);
        rst_n = 1'b1;
        step(2);
    endtask

    // Press and hold one key long enough for exactly nev events, then release.
    task automatic run_key(input int idx, input int nev, input int codes[6], input logic m);
        int n, h;
        int offs[6];
        offs = '{7, 27, 32, 37, 42, 47};
        n = cyc;
        b[idx] = 1'b1;
        for (int k = 0; k < nev; k++) push(codes[k], m, n + offs[k]);
        h = (nev == 1) ? 10 : offs[nev-1] - 4;
        step(h);
        b[idx] = 1'b0;
        step(12);
    endtask

    initial begin : stim
        int n, r;

        // 1: clean up press, +1 after 2+4+1 cycles
        do_reset();
        run_key(1, 1, '{70, 0, 0, 0, 0, 0}, 1'b0);
        step(10);

        // 2: bouncing up never settles, then a 5-cycle stable press
        do_reset();
        for (int k = 0; k < 10; k++) begin
            b[1] = 1'b1; step(3);
            b[1] = 1'b0; step(1);
        end
        step(10);
        check("glitch_code", code, 69);
        n = cyc;
        b[1] = 1'b1;
        push(70, 1'b0, n + 7);
        step(5);
        b[1] = 1'b0;
        step(15);

        // 3: held octave-up with saturation at 127
        do_reset();
        run_key(3, 6, '{81, 93, 105, 117, 127, 127}, 1'b0);

        // 4: walk down to 5, left saturates to 0, held down stays at 0
        do_reset();
        run_key(4, 5, '{57, 45, 33, 21, 9, 0}, 1'b0);
        run_key(2, 4, '{8, 7, 6, 5, 0, 0}, 1'b0);
        run_key(4, 1, '{0, 0, 0, 0, 0, 0}, 1'b0);
        run_key(2, 3, '{0, 0, 0, 0, 0, 0}, 1'b0);
        step(40);
        check("floor_code", code, 0);

        // 5: center collides with an up repeat, then down takes over
        do_reset();
        n = cyc;
        b[1] = 1'b1;
        push(70, 1'b0, n + 7);
        push(71, 1'b0, n + 27);
        push(72, 1'b0, n + 32);
        step(30);
        b[0] = 1'b1;
        push(72, 1'b1, n + 37);
        push(73, 1'b1, n + 38);
        push(74, 1'b1, n + 43);
        push(75, 1'b1, n + 48);
        step(8);
        b[0] = 1'b0;
        step(7);
        b[2] = 1'b1;
        push(74, 1'b1, n + 52);
        push(73, 1'b1, n + 72);
        push(72, 1'b1, n + 77);
        step(28);
        b[2] = 1'b0;
        b[1] = 1'b0;
        step(12);
        check("mute_held", mute, 1);

        // 6: simultaneous up+down, async reset in REPEAT, fresh debounce after
        do_reset();
        n = cyc;
        b[1] = 1'b1;
        b[2] = 1'b1;
        push(70, 1'b0, n + 7);
        push(71, 1'b0, n + 27);
        push(72, 1'b0, n + 32);
        step(34);
        check("pre_rst_code", code, 72);
        rst_n = 1'b0;
        #1;
        check("async_rst_code", code, 69);
        check("async_rst_mute", mute, 0);
        check("async_rst_event", key_event, 0);
        step(3);
        rst_n = 1'b1;
        r = cyc;
        push(70, 1'b0, r + 7);
        step(10);
        b = '0;
        step(12);

        step(5);
        check("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
